// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file with post-reset clear engine; REGFILE_BYPASS_EN selects write-first forwarding
module regfile_2r1w #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ZERO_REG0 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren0,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  ren1,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy
);
  localparam int DEPTH = 2**ADDR_WIDTH;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] idx, idx_next;
  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DATA_WIDTH-1:0] rd0, rd1;
  logic last, we, zero0, zero1;
  always_comb begin
    last = idx == ADDR_WIDTH'(DEPTH - 1);
    state_next = state == CLEAR && last ? READY : state;
    idx_next = state == CLEAR && !last ? idx + 1'b1 : idx;
    we = state == READY && wen && !(ZERO_REG0 != 0 && waddr == '0);
    zero0 = ZERO_REG0 != 0 && raddr0 == '0;
    zero1 = ZERO_REG0 != 0 && raddr1 == '0;
    rd0 = zero0 ? '0 : BYPASS && wen && waddr == raddr0 ? wdata : rf[raddr0];
    rd1 = zero1 ? '0 : BYPASS && wen && waddr == raddr1 ? wdata : rf[raddr1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx <= '0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      state <= state_next;
      idx <= idx_next;
      if (state == CLEAR) begin
        rdata0 <= '0;
        rdata1 <= '0;
      end else begin
        if (ren0) rdata0 <= rd0;
        if (ren1) rdata1 <= rd1;
      end
    end
  end
  // storage has no reset of its own; the clear engine zeroes it one entry per edge
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) rf[idx] <= '0;
    else if (!rst && we) rf[waddr] <= wdata;
  end
  assign busy = state == CLEAR;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: random + directed bench checking two DUTs (ZERO_REG0=1 and 0) against an array model
module tb_regfile_2r1w;
  localparam int AW = 5, DW = 32, DEPTH = 32;
  logic clk = 0, rst = 1, wen = 0, ren0 = 0, ren1 = 0;
  logic [AW-1:0] waddr = 0, raddr0 = 0, raddr1 = 0;
  logic [DW-1:0] wdata = 0;
  logic [DW-1:0] q0 [2], q1 [2];
  logic bz [2];
  int checks = 0, errors = 0;
  logic [DW-1:0] mem [2][DEPTH];
  logic [DW-1:0] e0 [2], e1 [2];
  bit bm = 1;
  int left = DEPTH;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  always #5 clk = ~clk;
  regfile_2r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG0(1)) u_z (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren0(ren0), .raddr0(raddr0), .rdata0(q0[0]),
    .ren1(ren1), .raddr1(raddr1), .rdata1(q1[0]), .busy(bz[0]));
  regfile_2r1w #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG0(0)) u_n (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .ren0(ren0), .raddr0(raddr0), .rdata0(q0[1]),
    .ren1(ren1), .raddr1(raddr1), .rdata1(q1[1]), .busy(bz[1]));
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rd(input int z, input logic [AW-1:0] a);
    if (z == 0 && a == 0) return '0;
    if (BYP && wen && waddr == a) return wdata;
    return mem[z][a];
  endfunction
  task automatic step();
    @(posedge clk);
    if (rst) begin
      bm = 1;
      left = DEPTH;
      for (int z = 0; z < 2; z++) begin e0[z] = '0; e1[z] = '0; end
    end else if (bm) begin
      for (int z = 0; z < 2; z++) begin mem[z][DEPTH-left] = '0; e0[z] = '0; e1[z] = '0; end
      left--;
      if (left == 0) bm = 0;
    end else begin
      for (int z = 0; z < 2; z++) begin
        if (ren0) e0[z] = rd(z, raddr0);
        if (ren1) e1[z] = rd(z, raddr1);
        if (wen && !(z == 0 && waddr == 0)) mem[z][waddr] = wdata;
      end
    end
    #1;
    for (int z = 0; z < 2; z++) begin
      chk(z ? "busy_n" : "busy_z", {31'b0, bz[z]}, {31'b0, bm});
      chk(z ? "rdata0_n" : "rdata0_z", q0[z], e0[z]);
      chk(z ? "rdata1_n" : "rdata1_z", q1[z], e1[z]);
    end
  endtask
  task automatic idle();
    wen = 0; ren0 = 0; ren1 = 0;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle(); wen = 1; waddr = a; wdata = d; step();
  endtask
  task automatic rd2(input logic [AW-1:0] a, input logic [AW-1:0] b);
    idle(); ren0 = 1; raddr0 = a; ren1 = 1; raddr1 = b; step();
  endtask
  task automatic clear_with_traffic();
    int n = 0;
    wen = 1; waddr = 5; wdata = 32'hAA; ren1 = 1; raddr1 = 5;
    while (bm && n < 100) begin step(); n++; end
    chk("clear_len", n, DEPTH);
    idle();
  endtask
  initial begin
    idle();
    rst = 1; step(); step();
    chk("reset_busy", {31'b0, bz[0]}, 32'd1);
    rst = 0;
    wen = 1; waddr = 5; wdata = 32'hAA; ren1 = 1; raddr1 = 5;
    for (int i = 0; i < 10; i++) step();
    rst = 1; step(); rst = 0;
    clear_with_traffic();
    rd2(5, 5);
    chk("addr5_after_clear", q1[1], 32'h0);
    for (int i = 0; i < DEPTH; i++) rd2(AW'(i), AW'(DEPTH - 1 - i));
    wr(7, 32'hDEADBEEF);
    rd2(7, 7);
    chk("basic0", q0[0], 32'hDEADBEEF);
    chk("basic1", q1[0], 32'hDEADBEEF);
    idle(); step();
    chk("hold0", q0[0], 32'hDEADBEEF);
    wr(0, 32'h12345678);
    rd2(0, 0);
    chk("zero_z", q0[0], 32'h0);
    chk("zero_n", q0[1], 32'h12345678);
    wr(3, 32'h11);
    idle(); wen = 1; waddr = 3; wdata = 32'h22; ren0 = 1; raddr0 = 3; step();
    chk("collide", q0[0], BYP ? 32'h22 : 32'h11);
    rd2(3, 3);
    chk("collide_next", q0[0], 32'h22);
    for (int i = 0; i < 2000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      wen = $urandom_range(0, 1) == 1;
      ren0 = $urandom_range(0, 3) != 0;
      ren1 = $urandom_range(0, 3) != 0;
      waddr = AW'($urandom_range(0, 7));
      raddr0 = AW'($urandom_range(0, 7));
      raddr1 = $urandom_range(0, 1) ? waddr : AW'($urandom);
      wdata = $urandom;
      step();
    end
    idle(); rst = 0; step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised two-read/one-write register file, successor to the single-port register file used in the core datapath. Two independent read ports have a registered, enable-gated 1-cycle latency. One write port. Optional hardwired-zero entry 0. After reset, a sequential clear engine zeroes every entry and reports completion on `busy`. It sits between decode (read addresses) and writeback (write port) of the CPU pipeline.

## Interface
Parameters:
- `ADDR_WIDTH`, default 5: address width; depth `DEPTH = 2**ADDR_WIDTH`.
- `DATA_WIDTH`, default 32: entry width.
- `ZERO_REG0`, default 1: when 1, entry 0 is hardwired zero.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `wen`  in  1  write enable.
- `waddr`  in  `ADDR_WIDTH`  write address.
- `wdata`  in  `DATA_WIDTH`  write data.
- `ren0` / `ren1`  in  1  read enable, port 0 / 1.
- `raddr0` / `raddr1`  in  `ADDR_WIDTH`  read address, port 0 / 1.
- `rdata0` / `rdata1`  out  `DATA_WIDTH`  registered read data, port 0 / 1.
- `busy`  out  1  high while the clear engine runs; no writes or reads are accepted.

## Operation
- State machine has two states, CLEAR and READY.
- `rst`=1 at an edge:
  - state ← CLEAR, clear index ← 0.
  - `rdata0` ← 0, `rdata1` ← 0, `busy` ← 1.
  - Holding `rst` high keeps index at 0.
- CLEAR (with `rst`=0):
  - Each edge writes 0 to `rf[index]` and increments index.
  - On the edge that clears `DEPTH-1`, state ← READY and `busy` ← 0.
  - `wen`, `ren0` and `ren1` are ignored; `rdata*` hold 0.
- READY, write: `wen`=1 → `rf[waddr]` ← `wdata` at the edge. If `ZERO_REG0`=1 and `waddr`=0, the write is dropped.
- READY, read port k:
  - `renk`=1 → `rdatak` ← `rf[raddrk]` at the edge.
  - `renk`=0 → `rdatak` holds its previous value.
  - If `ZERO_REG0`=1 and `raddrk`=0, `rdatak` ← 0 regardless of storage.
- Both ports may read the same address in the same cycle; both return the same value.
- `rst` asserted mid-CLEAR or mid-operation: the clear restarts from index 0. Any write in that cycle is dropped.
- Index counter is `ADDR_WIDTH` bits wide. It wraps to 0 only via reset and never in READY.

## Timing
- Reset values: `rdata0`=0, `rdata1`=0, `busy`=1.
- Clear duration: `busy` stays high for exactly `DEPTH` edges after the first edge with `rst`=0. It falls on the `DEPTH`-th edge.
- Write latency: data is visible to a read issued in the cycle after the write edge.
- Read latency: 1 cycle. Address and enable are sampled at edge N; data is valid after edge N.
- Same-cycle write and read to the same address (READY, nonzero address): behaviour is set by `REGFILE_BYPASS_EN`.
- No combinational path from any input to any output.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read on either port with `raddrk`==`waddr` and `wen`=1 in the same READY cycle returns `wdata`. This is write-first forwarding.
  - The zero-register rule still takes priority: address 0 returns 0 when `ZERO_REG0`=1.
- `REGFILE_BYPASS_EN` undefined:
  - Such a read returns the pre-write contents (read-first).
  - The new value is visible from the next read.

## Test plan
(ADDR_WIDTH=5, DATA_WIDTH=32, ZERO_REG0=1 unless stated.)
- Reset and clear:
  - Stimulus: pulse `rst` for 1 cycle.
  - Response: `busy`=1 for exactly 32 edges then 0. `rdata0`/`rdata1`=0 throughout. Afterwards a read of every address returns 0.
- Basic write/read:
  - Stimulus: write 0xDEADBEEF to addr 7, then next cycle `ren0`=1, `raddr0`=7 and `ren1`=1, `raddr1`=7.
  - Response: both `rdata` = 0xDEADBEEF one cycle later. With `ren0`=0 afterwards, `rdata0` holds 0xDEADBEEF.
- Zero register:
  - Stimulus: write 0x12345678 to addr 0, then read addr 0.
  - Response: `rdata`=0.
  - Stimulus (ZERO_REG0=0): same sequence.
  - Response: 0x12345678.
- Same-cycle collision:
  - Stimulus: addr 3 holds 0x11. In one cycle write 0x22 to addr 3 and read addr 3 on port 0.
  - Response: 0x22 with `REGFILE_BYPASS_EN` defined, 0x11 without. A read on the next cycle returns 0x22 in both builds.
- Ignored traffic during clear:
  - Stimulus: assert `wen` to addr 5 with 0xAA, and `ren1` to addr 5, on every cycle while `busy`=1.
  - Response: `rdata1` stays 0 during clear. A read of addr 5 after `busy` falls returns 0.
- Reset mid-clear:
  - Stimulus: assert `rst` 10 cycles into the clear.
  - Response: `busy` remains high for a full 32 edges after `rst` deasserts. Outputs are 0 throughout.
